mul_share_arb: RTL

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb_pkg.sv | 18 +
 rtl/mul_pipe.sv | 60 ++++++
 rtl/mul_share_arb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared types and constants for the two-requester shared-multiplier arbiter.
package mul_share_arb_pkg;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_t;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

    localparam int unsigned CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Unsigned multiplier pipeline: one operand register stage followed by LAT product
// stages, each carrying a valid bit and a requester tag.
module mul_pipe #(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 4,
    parameter int unsigned LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_tag,
    input  logic [A_W-1:0]       in_x,
    input  logic [B_W-1:0]       in_y,
    output logic                 out_valid,
    output logic                 out_tag,
    output logic [A_W+B_W-1:0]   out_data
);
    localparam int unsigned P_W = A_W + B_W;

    logic             op_valid;
    logic             op_tag;
    logic [A_W-1:0]   op_x;
    logic [B_W-1:0]   op_y;
    logic [LAT-1:0]   stg_valid;
    logic [LAT-1:0]   stg_tag;
    logic [P_W-1:0]   stg_data [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid  <= 1'b0;
            op_tag    <= 1'b0;
            op_x      <= '0;
            op_y      <= '0;
            stg_valid <= '0;
            stg_tag   <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                stg_data[i] <= '0;
            end
        end else begin
            op_valid     <= in_valid;
            op_tag       <= in_tag;
            op_x         <= in_x;
            op_y         <= in_y;
            // Zero-extend both operands to the full product width before multiplying.
            stg_valid[0] <= op_valid;
            stg_tag[0]   <= op_tag;
            stg_data[0]  <= P_W'(op_x) * P_W'(op_y);
            for (int unsigned i = 1; i < LAT; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_tag[i]   <= stg_tag[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
        end
    end

    assign out_valid = stg_valid[LAT-1];
    assign out_tag   = stg_tag[LAT-1];
    assign out_data  = stg_data[LAT-1];

endmodule

// File: rtl/mul_share_arb.sv
// Two requesters sharing one pipelined multiplier with alternating-priority arbitration.
// Optional saturating grant counters cnt_a/cnt_b when MUL_SHARE_ARB_CNT_EN is defined.
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 4,
    parameter int unsigned LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_a_valid,
    output logic                 req_a_ready,
    input  logic [A_W-1:0]       req_a_x,
    input  logic [B_W-1:0]       req_a_y,
    input  logic                 req_b_valid,
    output logic                 req_b_ready,
    input  logic [A_W-1:0]       req_b_x,
    input  logic [B_W-1:0]       req_b_y,
    output logic                 res_a_valid,
    output logic [A_W+B_W-1:0]   res_a_data,
    output logic                 res_b_valid,
    output logic [A_W+B_W-1:0]   res_b_data
`ifdef MUL_SHARE_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]     cnt_a,
    output logic [CNT_W-1:0]     cnt_b
`endif
);
    arb_state_t           state;
    arb_state_t           state_next;
    logic                 grant_a;
    logic                 grant_b;
    logic                 issue_tag;
    logic [A_W-1:0]       issue_x;
    logic [B_W-1:0]       issue_y;
    logic                 pipe_valid;
    logic                 pipe_tag;
    logic [A_W+B_W-1:0]   pipe_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PRI_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        if (req_a_valid && (!req_b_valid || state == PRI_A)) begin
            grant_a = 1'b1;
        end else if (req_b_valid) begin
            grant_b = 1'b1;
        end
        if (grant_a) begin
            state_next = PRI_B;
        end else if (grant_b) begin
            state_next = PRI_A;
        end
    end

    assign req_a_ready = grant_a;
    assign req_b_ready = grant_b;
    assign issue_tag   = grant_b ? TAG_B : TAG_A;
    assign issue_x     = grant_b ? req_b_x : req_a_x;
    assign issue_y     = grant_b ? req_b_y : req_a_y;

    mul_pipe #(
        .A_W (A_W),
        .B_W (B_W),
        .LAT (LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (grant_a | grant_b),
        .in_tag    (issue_tag),
        .in_x      (issue_x),
        .in_y      (issue_y),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data)
    );

    // Result registers add the final cycle of latency; data holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_a_valid <= 1'b0;
            res_b_valid <= 1'b0;
            res_a_data  <= '0;
            res_b_data  <= '0;
        end else begin
            res_a_valid <= pipe_valid && (pipe_tag == TAG_A);
            res_b_valid <= pipe_valid && (pipe_tag == TAG_B);
            if (pipe_valid && (pipe_tag == TAG_A)) begin
                res_a_data <= pipe_data;
            end
            if (pipe_valid && (pipe_tag == TAG_B)) begin
                res_b_data <= pipe_data;
            end
        end
    end

`ifdef MUL_SHARE_ARB_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (grant_a) begin
                cnt_a <= sat_inc(cnt_a);
            end
            if (grant_b) begin
                cnt_b <= sat_inc(cnt_b);
            end
        end
    end
`endif

endmodule
